conv_out_stage: RTL and testbench
=================================

Name: conv_out_stage

Overview:
- Downstream stage of the convolution controller. Consumes its 11-bit signed Q4.6 convolution results, each qualified by a one-cycle ready pulse.
- Applies ReLU, rounds and saturates each result to an 8-bit unsigned pixel, and buffers it in a small FIFO.
- Presents pixels to the chip output interface over a valid/ready handshake.
- Tracks pixels delivered per frame and flags input overflow.

Parameters:
- IN_WIDTH, 11, input width (Q4.6, two's complement).
- OUT_WIDTH, 8, output pixel width.
- OUT_SHIFT, 2, right shift applied after ReLU.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- FRAME_PIXELS, 16, pixels per frame. Max 2^24-1.

Ports:
- clk_i  in  1  clock, rising edge.
- nreset_i  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous flush: pipeline, FIFO, frame counter, overflow flag.
- in_px_i  in  11  convolution result, Q4.6 signed.
- in_rdy_i  in  1  one-cycle pulse; in_px_i valid this cycle.
- px_o  out  8  output pixel (FIFO head).
- px_valid_o  out  1  px_o holds a valid pixel.
- px_ack_i  in  1  downstream ready; a pop occurs when px_valid_o && px_ack_i.
- frame_done_o  out  1  one-cycle pulse after the FRAME_PIXELS-th pop.
- overflow_o  out  1  sticky; an input was dropped because the FIFO was full.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, nreset_i=0): all outputs 0; pipeline register invalid; FIFO empty; frame counter 0. Reset mid-transfer discards all buffered pixels.
- Quantization (combinational on in_px_i):
  - r = (in_px_i < 0) ? 0 : in_px_i.
  - q = (r + 2^(OUT_SHIFT-1)) >> OUT_SHIFT, round half up; if OUT_SHIFT=0, q = r.
  - px = (q > 255) ? 255 : q[7:0].
  - The internal sum uses IN_WIDTH+1 bits, so no wrap occurs.
- Stage 1: on an edge with in_rdy_i=1, register px into q_reg and set q_vld=1; otherwise q_vld=0.
- Stage 2: on an edge with q_vld=1, push q_reg into the FIFO.
- Latency: an input sampled at edge E0 appears on px_o with px_valid_o=1 after edge E1 (2 cycles) when the FIFO was empty. There is no fall-through.
- FIFO:
  - Circular buffer with read/write pointers and one extra wrap bit.
  - px_o is combinational from the head entry.
  - px_valid_o = (level != 0).
- Push and pop on the same edge:
  - Allowed at any level, including full; level is unchanged and both pointers advance.
  - A push when full with no pop is dropped: FIFO unchanged, overflow_o set to 1 and held until clr_i or reset.
- px_ack_i while empty: ignored.
- Frame counter (24 bit):
  - Increments on each pop.
  - When a pop takes it to FRAME_PIXELS, it wraps to 0 and frame_done_o pulses 1 for the following cycle only.
- clr_i=1:
  - On that edge: q_vld=0, FIFO emptied, counter=0, overflow_o=0, frame_done_o=0.
  - clr_i has priority over a simultaneous in_rdy_i, push or pop; the in_rdy_i input is lost.
- Back-to-back in_rdy_i pulses (every cycle) are accepted while the FIFO is not full.
- Pointer wrap-around at FIFO_DEPTH is seamless.

Decomposition:
- Shared package cnn_pkg holds:
  - BITS_Q4_6=11, PIXEL_WIDTH_OUT=8, MAX_RESOLUTION_BITS=24.
  - A function sat_relu_q46(in, shift) returning the 8-bit pixel, shared with the bench reference model.
- Sub-module px_fifo:
  - Parameterized WIDTH/DEPTH synchronous FIFO.
  - Signals: push, pop, full, empty, level, head data.
  - Flush input driven by clr_i.
- conv_out_stage instantiates px_fifo and contains the quantizer, stage-1 register, frame counter and overflow logic.

Test Plan:
- Quantization: pulse in_px_i 0x0C0, 0x0C2, 0x0C1, 0x3FF, 0x7C0 (-64), 0x400 (-1024), px_ack_i=1 → px_o = 48, 49, 48, 255, 0, 0 in order; each first valid 2 cycles after its pulse.
- Backpressure and overflow: px_ack_i=0, 6 consecutive pulses with values 1..6 (×4) → fifo_level_o=4 and overflow_o=1. Then px_ack_i=1 → pops 1,2,3,4 and the FIFO empties; overflow_o stays 1 until clr_i.
- Full with simultaneous push/pop: FIFO holding 4 entries, pulse in_rdy_i (value 0x028) with px_ack_i=1 on the push edge → level stays 4, overflow_o stays 0, 0x028 → px_o=10 delivered last.
- Frame: FRAME_PIXELS=16, 32 inputs with continuous ack → frame_done_o pulses exactly twice, one cycle after the 16th and 32nd pops; counter returns to 0.
- Flush/reset mid-stream: 3 entries buffered plus q_vld=1, assert clr_i one cycle → px_valid_o=0 next cycle, level=0, no stale pixel ever appears. Repeat with nreset_i low for a half cycle → all outputs 0 immediately.
- Pointer wrap: stream 100 random Q4.6 values with random px_ack_i → output sequence matches sat_relu_q46 model order, with no loss while overflow_o=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output path.
// Holds the fixed-point widths used across the convolution blocks and the
// ReLU / round / saturate helper that maps a Q4.6 result onto an 8-bit pixel.
package cnn_pkg;

  localparam int unsigned BITS_Q4_6           = 11;
  localparam int unsigned PIXEL_WIDTH_OUT     = 8;
  localparam int unsigned MAX_RESOLUTION_BITS = 24;

  // ReLU, round-half-up right shift, then saturate to PIXEL_WIDTH_OUT bits.
  // One guard bit on the sum keeps the rounding increment from wrapping.
  function automatic logic [PIXEL_WIDTH_OUT-1:0] sat_relu_q46(
    input logic [BITS_Q4_6-1:0] din,
    input int unsigned          shift
  );
    logic [BITS_Q4_6:0] r;
    logic [BITS_Q4_6:0] q;
    logic [BITS_Q4_6:0] half;
    r    = din[BITS_Q4_6-1] ? '0 : {1'b0, din};
    half = '0;
    if (shift == 0) begin
      q = r;
    end else begin
      half = {{BITS_Q4_6{1'b0}}, 1'b1} << (shift - 1);
      q    = (r + half) >> shift;
    end
    if (|q[BITS_Q4_6:PIXEL_WIDTH_OUT]) begin
      return '1;
    end
    return q[PIXEL_WIDTH_OUT-1:0];
  endfunction

endpackage

// File: rtl/px_fifo.sv
// Small synchronous pixel FIFO.
// Circular buffer with an extra wrap bit on each pointer so that full and
// empty are distinguished by the pointer difference.
// Ports:
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   flush           : synchronous empty, wins over push/pop
//   push, wr_data   : write request and data
//   pop             : read request (ignored while empty)
//   rd_data         : head entry, combinational
//   full, empty     : occupancy flags
//   level           : current occupancy, 0..DEPTH
module px_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wptr - rptr;
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign rd_data = mem[rptr[AW-1:0]];

  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_out_stage.sv
// Output stage of the convolution controller.
// Quantizes each Q4.6 result (ReLU, round, saturate), registers it for one
// cycle, buffers it in px_fifo and hands pixels downstream over valid/ack.
// Also counts delivered pixels per frame and flags dropped inputs.
// Ports:
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   clr_i           : synchronous flush of pipeline, FIFO, counter, overflow
//   in_px_i/in_rdy_i: convolution result and its one-cycle qualifier
//   px_o/px_valid_o : FIFO head pixel and its valid flag
//   px_ack_i        : downstream ready; pop when valid && ack
//   frame_done_o    : one-cycle pulse after the last pixel of a frame
//   overflow_o      : sticky, an input was dropped on a full FIFO
//   fifo_level_o    : FIFO occupancy
module conv_out_stage
  import cnn_pkg::*;
#(
  parameter int unsigned IN_WIDTH     = BITS_Q4_6,
  parameter int unsigned OUT_WIDTH    = PIXEL_WIDTH_OUT,
  parameter int unsigned OUT_SHIFT    = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FRAME_PIXELS = 16
) (
  input  logic                            clk_i,
  input  logic                            nreset_i,
  input  logic                            clr_i,
  input  logic [IN_WIDTH-1:0]             in_px_i,
  input  logic                            in_rdy_i,
  output logic [OUT_WIDTH-1:0]            px_o,
  output logic                            px_valid_o,
  input  logic                            px_ack_i,
  output logic                            frame_done_o,
  output logic                            overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

  localparam logic [MAX_RESOLUTION_BITS-1:0] FRAME_LAST =
    MAX_RESOLUTION_BITS'(FRAME_PIXELS - 1);
  localparam logic [MAX_RESOLUTION_BITS-1:0] CNT_ONE =
    MAX_RESOLUTION_BITS'(1);

  logic [OUT_WIDTH-1:0]           px_quant;
  logic [OUT_WIDTH-1:0]           q_reg;
  logic                           q_vld;
  logic [OUT_WIDTH-1:0]           head;
  logic                           full;
  logic                           empty;
  logic                           pop;
  logic [MAX_RESOLUTION_BITS-1:0] frame_cnt;

  assign px_quant = OUT_WIDTH'(sat_relu_q46(BITS_Q4_6'(in_px_i), OUT_SHIFT));

  assign px_valid_o = !empty;
  assign pop        = px_valid_o && px_ack_i;
  // Head is masked while empty so no stale buffer content is ever visible.
  assign px_o       = px_valid_o ? head : '0;

  // Stage 1: quantized sample register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      q_vld <= 1'b0;
      q_reg <= '0;
    end else if (clr_i) begin
      q_vld <= 1'b0;
    end else begin
      q_vld <= in_rdy_i;
      if (in_rdy_i) q_reg <= px_quant;
    end
  end

  // Stage 2: FIFO.
  px_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .flush    (clr_i),
    .push     (q_vld),
    .wr_data  (q_reg),
    .pop      (pop),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level_o)
  );

  // Frame counter with a one-cycle done pulse following the wrap.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      frame_cnt    <= '0;
      frame_done_o <= 1'b0;
    end else if (clr_i) begin
      frame_cnt    <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (pop) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt    <= '0;
          frame_done_o <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + CNT_ONE;
        end
      end
    end
  end

  // A push is lost only when full and the head is not leaving on that edge.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      overflow_o <= 1'b0;
    end else if (clr_i) begin
      overflow_o <= 1'b0;
    end else if (q_vld && full && !pop) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_out_stage.sv
module tb_conv_out_stage;

  localparam int DEPTH = 4;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        nreset;
  logic        clr;
  logic [10:0] in_px;
  logic        in_rdy;
  logic [7:0]  px;
  logic        px_valid;
  logic        px_ack;
  logic        frame_done;
  logic        overflow;
  logic [2:0]  level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic       m_qv;
  logic [7:0] m_q;
  logic       m_ovf;
  logic       m_fd;
  int         m_cnt;

  always #5 clk = ~clk;

  conv_out_stage #(
    .IN_WIDTH     (11),
    .OUT_WIDTH    (8),
    .OUT_SHIFT    (2),
    .FIFO_DEPTH   (DEPTH),
    .FRAME_PIXELS (FRAME)
  ) dut (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .clr_i        (clr),
    .in_px_i      (in_px),
    .in_rdy_i     (in_rdy),
    .px_o         (px),
    .px_valid_o   (px_valid),
    .px_ack_i     (px_ack),
    .frame_done_o (frame_done),
    .overflow_o   (overflow),
    .fifo_level_o (level)
  );

  function automatic logic [7:0] ref_px(input logic [10:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = 0;
    v = (v + 2) / 4;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic model_reset();
    m_qv  = 1'b0;
    m_q   = 8'h00;
    m_ovf = 1'b0;
    m_fd  = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1ns.
  task automatic tick(input logic rdy, input logic [10:0] x, input logic ack, input logic c);
    int sz;
    bit pop;
    in_rdy = rdy; in_px = x; px_ack = ack; clr = c;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      sz  = exp_q.size();
      pop = (sz != 0) && ack;
      m_fd = 1'b0;
      if (pop) begin
        void'(exp_q.pop_front());
        m_cnt++;
        if (m_cnt == FRAME) begin
          m_cnt = 0;
          m_fd  = 1'b1;
        end
      end
      if (m_qv) begin
        if (sz == DEPTH && !pop) m_ovf = 1'b1;
        else exp_q.push_back(m_q);
      end
      m_qv = rdy;
      m_q  = ref_px(x);
    end
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; clr = 1'b0; in_rdy = 1'b0; in_px = '0; px_ack = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if ({px, px_valid, level, overflow, frame_done} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {px, px_valid, level, overflow, frame_done});
    end
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({px_valid, level} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0", {px_valid, level});
    end
  endtask

  task automatic test_quant();
    logic [10:0] vin [6];
    logic [7:0]  vexp[6];
    vin  = '{11'h0C0, 11'h0C2, 11'h0C1, 11'h3FF, 11'h7C0, 11'h400};
    vexp = '{8'd48, 8'd49, 8'd48, 8'd255, 8'd0, 8'd0};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, vin[i], 1'b1, 1'b0);
      n_checks++;
      if (px_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL quant_no_fallthrough[%0d]: got %b expected 0", i, px_valid);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({px_valid, px} !== {1'b1, vexp[i]}) begin
        n_fail++;
        $display("FAIL quant_px[%0d]: got valid=%b px=%0d expected valid=1 px=%0d", i, px_valid, px, vexp[i]);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if (px_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL quant_popped[%0d]: got %b expected 0", i, px_valid);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) tick(1'b1, 11'(4 * i), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if ({level, overflow} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_full: got level=%0d ovf=%b expected level=4 ovf=1", level, overflow);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if ({px_valid, px} !== {1'b1, 8'(i)}) begin
        n_fail++;
        $display("FAIL ovf_pop[%0d]: got valid=%b px=%0d expected valid=1 px=%0d", i, px_valid, px, i);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if ({px_valid, level, overflow} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_drained: got valid=%b level=%0d ovf=%b expected 0 0 1", px_valid, level, overflow);
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] order[4];
    order = '{8'd2, 8'd3, 8'd4, 8'd10};
    for (int i = 1; i <= 4; i++) tick(1'b1, 11'(4 * i), 1'b0, 1'b0);
    tick(1'b1, 11'h028, 1'b0, 1'b0);
    n_checks++;
    if ({level, overflow} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL pp_full: got level=%0d ovf=%b expected 4 0", level, overflow);
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if ({level, overflow, px} !== {3'd4, 1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL pp_same_edge: got level=%0d ovf=%b px=%0d expected 4 0 2", level, overflow, px);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({px_valid, px} !== {1'b1, order[k]}) begin
        n_fail++;
        $display("FAIL pp_order[%0d]: got valid=%b px=%0d expected valid=1 px=%0d", k, px_valid, px, order[k]);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if ({px_valid, overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL pp_end: got valid=%b ovf=%b expected 0 0", px_valid, overflow);
    end
  endtask

  task automatic test_frame();
    int pulses = 0;
    logic [13:0] act_s, exp_s;
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 35; k++) begin
      if (k < 32) tick(1'b1, 11'(16 * k + 3), 1'b1, 1'b0);
      else        tick(1'b0, '0, 1'b1, 1'b0);
      if (frame_done === 1'b1) pulses++;
      act_s = {px_valid, level, overflow, frame_done, (px_valid ? px : 8'h00)};
      exp_s = {exp_q.size() != 0, 3'(exp_q.size()), m_ovf, m_fd,
               (exp_q.size() != 0 ? exp_q[0] : 8'h00)};
      n_checks++;
      if (act_s !== exp_s) begin
        n_fail++;
        $display("FAIL frame_state[%0d]: got %h expected %h", k, act_s, exp_s);
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL frame_pulses: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_flush_reset();
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) tick(1'b1, 11'(40 * i), 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_prefill: got level=%0d expected 3", level);
    end
    tick(1'b1, 11'h100, 1'b1, 1'b1);
    n_checks++;
    if ({px_valid, level} !== 4'h0) begin
      n_fail++;
      $display("FAIL flush_empty: got valid=%b level=%0d expected 0 0", px_valid, level);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({px_valid, level} !== 4'h0) begin
        n_fail++;
        $display("FAIL flush_stale[%0d]: got valid=%b level=%0d expected 0 0", i, px_valid, level);
      end
    end
    for (int i = 1; i <= 6; i++) tick(1'b1, 11'(8 * i), 1'b0, 1'b0);
    nreset = 1'b0;
    #2;
    n_checks++;
    if ({px, px_valid, level, overflow, frame_done} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected 0", {px, px_valid, level, overflow, frame_done});
    end
    @(negedge clk);
    in_rdy = 1'b0;
    nreset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({px_valid, level, overflow} !== 5'h0) begin
        n_fail++;
        $display("FAIL reset_stale[%0d]: got valid=%b level=%0d ovf=%b expected 0", i, px_valid, level, overflow);
      end
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc  = 0;
    logic rdy, ack;
    logic [13:0] act_s, exp_s;
    tick(1'b0, '0, 1'b0, 1'b1);
    while ((sent < 100 || exp_q.size() != 0 || m_qv) && cyc < 1000) begin
      rdy = (sent < 100) && ($urandom_range(0, 3) != 0);
      ack = (sent >= 100) || ($urandom_range(0, 2) != 0);
      tick(rdy, 11'($urandom_range(0, 2047)), ack, 1'b0);
      if (rdy) sent++;
      cyc++;
      act_s = {px_valid, level, overflow, frame_done, (px_valid ? px : 8'h00)};
      exp_s = {exp_q.size() != 0, 3'(exp_q.size()), m_ovf, m_fd,
               (exp_q.size() != 0 ? exp_q[0] : 8'h00)};
      n_checks++;
      if (act_s !== exp_s) begin
        n_fail++;
        $display("FAIL random_state[%0d]: got %h expected %h", cyc, act_s, exp_s);
      end
    end
    n_checks++;
    if (cyc >= 1000) begin
      n_fail++;
      $display("FAIL random_timeout: got %0d cycles expected < 1000", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_quant();
    test_overflow();
    test_full_pushpop();
    test_frame();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
